// File: rtl/uart_receiver_pkg.sv
// Shared UART receive constants: default baud divisor and receiver state encoding.
package uart_receiver_pkg;

  // 12 MHz board clock at 115200 baud.
  localparam int DEFAULT_CLOCKS_PER_BAUD = 104;

  localparam int StateBits = 3;

  typedef enum logic [StateBits-1:0] {
    Idle     = 3'd0,
    StartBit = 3'd1,
    DataBits = 3'd2,
    StopBit  = 3'd3,
    WaitIdle = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop metastability guard for an asynchronous input; resets to the idle-high level.
module uart_rx_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: mid-bit sampling of a synchronized rx line, byte handoff with
// valid/done handshake, one-cycle framing-error pulse and sticky overrun flag.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int ClocksPerBaud = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_byte_out,
  output logic       rx_byte_valid_out,
  input  logic       rx_byte_done,
  output logic       rx_byte_error_out,
  output logic       rx_overrun_out
);

  localparam int CntBits = $clog2(ClocksPerBaud);
  localparam logic [CntBits-1:0] CntLast     = CntBits'(ClocksPerBaud - 1);
  localparam logic [CntBits-1:0] CntHalfLast = CntBits'(ClocksPerBaud / 2 - 1);

  logic rx_s;

  uart_rx_synchronizer u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_in),
    .q_o (rx_s)
  );

  rx_state_e          state_q, state_d;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         byte_q, byte_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic               overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= Idle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = valid_q;
    error_d   = 1'b0;
    overrun_d = overrun_q;

    if (rx_byte_done && valid_q) begin
      valid_d = 1'b0;
    end

    case (state_q)
      Idle: begin
        if (!rx_s) begin
          state_d = StartBit;
          cnt_d   = '0;
        end
      end

      StartBit: begin
        if (cnt_q == CntHalfLast) begin
          if (rx_s) begin
            state_d = Idle;
          end else begin
            state_d = DataBits;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DataBits: begin
        if (cnt_q == CntLast) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StopBit;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StopBit: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            // A completing byte wins over a same-cycle done; overrun only if unconsumed.
            byte_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_byte_done) begin
              overrun_d = 1'b1;
            end
            state_d = Idle;
          end else begin
            error_d = 1'b1;
            state_d = WaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WaitIdle: begin
        if (rx_s) begin
          state_d = Idle;
        end
      end

      default: state_d = Idle;
    endcase
  end

  assign rx_byte_out       = byte_q;
  assign rx_byte_valid_out = valid_q;
  assign rx_byte_error_out = error_q;
  assign rx_overrun_out    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 8 clocks per bit: framing, handshake, glitch, break, overrun.
module tb_uart_receiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_byte_done = 1'b0;
  logic [7:0] rx_byte_out;
  logic       rx_byte_valid_out;
  logic       rx_byte_error_out;
  logic       rx_overrun_out;

  uart_receiver #(.ClocksPerBaud(CPB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_in             (rx_in),
    .rx_byte_out       (rx_byte_out),
    .rx_byte_valid_out (rx_byte_valid_out),
    .rx_byte_done      (rx_byte_done),
    .rx_byte_error_out (rx_byte_error_out),
    .rx_overrun_out    (rx_overrun_out)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: valid rising edges, error-high cycles, overrun-high cycles.
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    valid_prev <= rx_byte_valid_out;
    if (rx_byte_valid_out === 1'b1 && valid_prev !== 1'b1) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
      got_q.push_back(rx_byte_out);
    end
    if (rx_byte_error_out === 1'b1) err_cnt <= err_cnt + 1;
    if (rx_overrun_out === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    $display("tx frame 0x%02h stop=%0d at cycle %0d", b, stop, cyc);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      tick(CPB);
    end
    rx_in = stop;
    tick(CPB);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (rx_byte_valid_out !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check_vec(tag, {31'd0, rx_byte_valid_out}, 32'd1);
  endtask

  task automatic pulse_done(input string tag);
    rx_byte_done = 1'b1;
    tick(1);
    rx_byte_done = 1'b0;
    check_vec(tag, {31'd0, rx_byte_valid_out}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int r0;
  int edge_cyc;
  int lat;

  initial begin
    // Reset and long idle line.
    tick(5);
    check_vec("rst_byte", {24'd0, rx_byte_out}, 32'h00);
    check_vec("rst_valid", {31'd0, rx_byte_valid_out}, 32'd0);
    check_vec("rst_error", {31'd0, rx_byte_error_out}, 32'd0);
    check_vec("rst_overrun", {31'd0, rx_overrun_out}, 32'd0);
    rst = 1'b0;
    tick(200);
    check_vec("idle_rises", rise_cnt, 0);
    check_vec("idle_errors", err_cnt, 0);
    check_vec("idle_overrun", ovr_cnt, 0);
    check_vec("idle_state", 32'(dut.state_q), 32'd0);

    // Single frame 0x41 with latency bound from the falling edge.
    r0 = rise_cnt;
    edge_cyc = cyc;
    send_frame(8'h41, 1'b1);
    tick(2);
    lat = rise_cyc - edge_cyc;
    $display("rx 0x%02h latency %0d cycles", rx_byte_out, lat);
    check_vec("b41_rises", rise_cnt - r0, 1);
    check_vec("b41_latency_in_window", {31'd0, (lat >= 77 && lat <= 80)}, 32'd1);
    check_vec("b41_byte", {24'd0, rx_byte_out}, 32'h41);
    check_vec("b41_valid", {31'd0, rx_byte_valid_out}, 32'd1);
    pulse_done("b41_done_clears");
    tick(3);
    check_vec("b41_stays_clear", {31'd0, rx_byte_valid_out}, 32'd0);

    // Back-to-back frames with a prompt consumer.
    got_q.delete();
    r0 = rise_cnt;
    fork
      begin
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        send_frame(8'h43, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid($sformatf("b2b_wait%0d", k), 200);
          tick(1);
          rx_byte_done = 1'b1;
          tick(1);
          rx_byte_done = 1'b0;
        end
      end
    join
    tick(4);
    check_vec("b2b_rises", rise_cnt - r0, 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) begin
        $display("rx b2b byte %0d = 0x%02h", k, got_q[k]);
        check_vec($sformatf("b2b_byte%0d", k), {24'd0, got_q[k]}, 32'h41 + k);
      end
    end
    check_vec("b2b_overrun", {31'd0, rx_overrun_out}, 32'd0);
    check_vec("b2b_valid_cleared", {31'd0, rx_byte_valid_out}, 32'd0);

    // Short low glitch, then a real frame.
    r0 = rise_cnt;
    rx_in = 1'b0;
    tick(2);
    rx_in = 1'b1;
    tick(20);
    check_vec("glitch_rises", rise_cnt - r0, 0);
    check_vec("glitch_errors", err_cnt, 0);
    check_vec("glitch_state", 32'(dut.state_q), 32'd0);
    send_frame(8'h55, 1'b1);
    wait_valid("b55_wait", 10);
    check_vec("b55_byte", {24'd0, rx_byte_out}, 32'h55);
    pulse_done("b55_done_clears");

    // Framing error followed by a break, then recovery.
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b0);
    tick(40);
    rx_in = 1'b1;
    tick(10);
    $display("rx framing error count %0d", err_cnt);
    check_vec("brk_error_once", err_cnt, 1);
    check_vec("brk_rises", rise_cnt - r0, 0);
    check_vec("brk_valid", {31'd0, rx_byte_valid_out}, 32'd0);
    check_vec("brk_byte_kept", {24'd0, rx_byte_out}, 32'h55);
    send_frame(8'h3C, 1'b1);
    wait_valid("b3c_wait", 10);
    check_vec("b3c_byte", {24'd0, rx_byte_out}, 32'h3C);
    pulse_done("b3c_done_clears");
    check_vec("b3c_error_total", err_cnt, 1);

    // Overrun: two bytes, never consumed, then reset.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(2);
    $display("rx overrun byte 0x%02h overrun=%0d", rx_byte_out, rx_overrun_out);
    check_vec("ovr_byte", {24'd0, rx_byte_out}, 32'h22);
    check_vec("ovr_valid", {31'd0, rx_byte_valid_out}, 32'd1);
    check_vec("ovr_flag", {31'd0, rx_overrun_out}, 32'd1);
    rst = 1'b1;
    tick(1);
    check_vec("rst2_byte", {24'd0, rx_byte_out}, 32'h00);
    check_vec("rst2_valid", {31'd0, rx_byte_valid_out}, 32'd0);
    check_vec("rst2_error", {31'd0, rx_byte_error_out}, 32'd0);
    check_vec("rst2_overrun", {31'd0, rx_overrun_out}, 32'd0);
    rst = 1'b0;
    tick(5);
    check_vec("rst2_overrun_stays", {31'd0, rx_overrun_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
